// File: rtl/dmem_responder_if.sv
// Bundled core dmem port and host preload/dump port of the data memory responder.
interface dmem_responder_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH_LOG2 = 8
);
  logic [ADDR_WIDTH-1:0] dmem_address;
  logic [DATA_WIDTH-1:0] dmem_dataIn;
  logic                  mem_enable;
  logic                  store_enable;
  logic [DATA_WIDTH-1:0] dmem_dataOut;
  logic                  host_valid;
  logic                  host_ready;
  logic                  host_write;
  logic [DEPTH_LOG2-1:0] host_addr;
  logic [DATA_WIDTH-1:0] host_wdata;
  logic [DATA_WIDTH-1:0] host_rdata;
  logic                  host_rvalid;
  logic                  oob_error;

  modport master (
    output dmem_address, dmem_dataIn, mem_enable, store_enable,
    output host_valid, host_write, host_addr, host_wdata,
    input  dmem_dataOut, host_ready, host_rdata, host_rvalid, oob_error
  );

  modport slave (
    input  dmem_address, dmem_dataIn, mem_enable, store_enable,
    input  host_valid, host_write, host_addr, host_wdata,
    output dmem_dataOut, host_ready, host_rdata, host_rvalid, oob_error
  );
endinterface

// File: rtl/dmem_responder.sv
// Single-port data memory: core port with one-cycle registered loads, plus a
// lower-priority valid/ready host port for preload and dump.
module dmem_responder #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic              clk,
  input  logic              rst,
  dmem_responder_if.slave   io_bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_RRESP = 1'b1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [0:0]            r_state;
  logic [DATA_WIDTH-1:0] r_core_rdata;
  logic [DATA_WIDTH-1:0] r_host_rdata;
  logic                  r_oob;

  logic [0:0]            w_state_nxt;
  logic                  w_core_in_range;
  logic                  w_core_load;
  logic                  w_host_ready;
  logic                  w_host_rd_acc;
  logic                  w_we;
  logic [DEPTH_LOG2-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [DATA_WIDTH-1:0] w_rdata;

  assign w_core_in_range = (io_bus.dmem_address[ADDR_WIDTH-1:DEPTH_LOG2]
                            == {(ADDR_WIDTH-DEPTH_LOG2){1'b0}});
  assign w_core_load     = io_bus.mem_enable & ~io_bus.store_enable;

  // Host handshake and FSM next state; the core pre-empts the host every cycle it is active.
  always_comb begin
    w_host_ready  = 1'b0;
    w_host_rd_acc = 1'b0;
    w_state_nxt   = S_IDLE;
    case (r_state)
      S_IDLE: begin
        w_host_ready  = ~io_bus.mem_enable & ~rst;
        w_host_rd_acc = io_bus.host_valid & w_host_ready & ~io_bus.host_write;
        if (w_host_rd_acc) begin
          w_state_nxt = S_RRESP;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RRESP: begin
        w_host_ready  = 1'b0;
        w_host_rd_acc = 1'b0;
        w_state_nxt   = S_IDLE;
      end
      default: begin
        w_host_ready  = 1'b0;
        w_host_rd_acc = 1'b0;
        w_state_nxt   = S_IDLE;
      end
    endcase
  end

  // Single array port: the owner of the cycle (core first, else host) drives address and write.
  always_comb begin
    w_addr  = {DEPTH_LOG2{1'b0}};
    w_wdata = {DATA_WIDTH{1'b0}};
    w_we    = 1'b0;
    if (io_bus.mem_enable) begin
      w_addr  = io_bus.dmem_address[DEPTH_LOG2-1:0];
      w_wdata = io_bus.dmem_dataIn;
      w_we    = io_bus.store_enable & w_core_in_range;
    end else begin
      w_addr  = io_bus.host_addr;
      w_wdata = io_bus.host_wdata;
      w_we    = io_bus.host_valid & w_host_ready & io_bus.host_write;
    end
  end

  assign w_rdata = r_mem[w_addr];

  // Array write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_addr] <= w_wdata;
    end
  end

  // Registered read data, sticky out-of-range flag and host FSM state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_core_rdata <= {DATA_WIDTH{1'b0}};
      r_host_rdata <= {DATA_WIDTH{1'b0}};
      r_oob        <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_core_load) begin
        r_core_rdata <= w_core_in_range ? w_rdata : {DATA_WIDTH{1'b0}};
      end
      if (io_bus.mem_enable & ~w_core_in_range) begin
        r_oob <= 1'b1;
      end
      if (w_host_rd_acc) begin
        r_host_rdata <= w_rdata;
      end
    end
  end

  assign io_bus.dmem_dataOut = r_core_rdata;
  assign io_bus.host_rdata   = r_host_rdata;
  assign io_bus.host_rvalid  = (r_state == S_RRESP);
  assign io_bus.host_ready   = w_host_ready;
  assign io_bus.oob_error    = r_oob;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder: reset, preload, core store/load,
// arbitration, host back-to-back reads, out-of-range and reset during a host read.
module tb_dmem_responder;
  logic clk;
  logic rst;
  int   errors;
  int   checks;

  localparam logic [63:0] PRELOAD5 = 64'h1122334455667788;
  localparam logic [63:0] BEEF     = 64'h00000000DEADBEEF;
  localparam logic [63:0] VAL3     = 64'hA5A5000000000003;
  localparam logic [63:0] VALFF    = 64'h0F0F0F0F0F0F00FF;

  dmem_responder_if #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .DEPTH_LOG2(8)) bus ();

  dmem_responder #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .DEPTH_LOG2(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    bus.mem_enable   = 1'b0;
    bus.store_enable = 1'b0;
    bus.dmem_address = 32'h0;
    bus.dmem_dataIn  = 64'h0;
    bus.host_valid   = 1'b0;
    bus.host_write   = 1'b0;
    bus.host_addr    = 8'h0;
    bus.host_wdata   = 64'h0;
  endtask

  task automatic host_write_word(input logic [7:0] a, input logic [63:0] d);
    @(negedge clk);
    idle_inputs();
    bus.host_valid = 1'b1; bus.host_write = 1'b1; bus.host_addr = a; bus.host_wdata = d;
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    @(negedge clk); #1;
    checks++; if (bus.host_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", bus.host_ready); end
    checks++; if (bus.dmem_dataOut !== 64'h0) begin errors++; $display("FAIL reset_dout: got %h want 0", bus.dmem_dataOut); end
    checks++; if (bus.host_rvalid !== 1'b0 || bus.host_rdata !== 64'h0 || bus.oob_error !== 1'b0) begin
      errors++; $display("FAIL reset_host_oob: rvalid=%b rdata=%h oob=%b want 0/0/0", bus.host_rvalid, bus.host_rdata, bus.oob_error);
    end
    rst = 1'b0; #1;
    checks++; if (bus.host_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", bus.host_ready); end
  endtask

  task automatic test_host_preload();
    @(negedge clk);
    bus.host_valid = 1'b1; bus.host_write = 1'b1; bus.host_addr = 8'd5; bus.host_wdata = PRELOAD5;
    #1;
    checks++; if (bus.host_ready !== 1'b1) begin errors++; $display("FAIL preload_ready: got %b want 1", bus.host_ready); end
    @(negedge clk);
    idle_inputs();
    bus.mem_enable = 1'b1; bus.dmem_address = 32'd5;
    checks++; if (bus.host_rvalid !== 1'b0) begin errors++; $display("FAIL preload_no_rvalid: got %b want 0", bus.host_rvalid); end
    @(negedge clk);
    checks++; if (bus.dmem_dataOut !== PRELOAD5) begin errors++; $display("FAIL preload_load: got %h want %h", bus.dmem_dataOut, PRELOAD5); end
    idle_inputs();
  endtask

  task automatic test_store_load();
    @(negedge clk);
    bus.mem_enable = 1'b1; bus.store_enable = 1'b1; bus.dmem_address = 32'h10; bus.dmem_dataIn = BEEF;
    @(negedge clk);
    checks++; if (bus.dmem_dataOut !== PRELOAD5) begin errors++; $display("FAIL store_dout_hold: got %h want %h", bus.dmem_dataOut, PRELOAD5); end
    bus.store_enable = 1'b0;
    @(negedge clk);
    checks++; if (bus.dmem_dataOut !== BEEF) begin errors++; $display("FAIL store_then_load: got %h want %h", bus.dmem_dataOut, BEEF); end
    idle_inputs();
    @(negedge clk);
    checks++; if (bus.dmem_dataOut !== BEEF) begin errors++; $display("FAIL idle_hold: got %h want %h", bus.dmem_dataOut, BEEF); end
  endtask

  task automatic test_arbitration();
    host_write_word(8'd3, VAL3);
    bus.host_valid = 1'b1; bus.host_write = 1'b0; bus.host_addr = 8'd3;
    bus.mem_enable = 1'b1; bus.dmem_address = 32'h10;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (bus.host_ready !== 1'b0) begin errors++; $display("FAIL arb_blocked%0d: got %b want 0", i, bus.host_ready); end
      @(negedge clk);
    end
    bus.mem_enable = 1'b0; #1;
    checks++; if (bus.host_ready !== 1'b1 || bus.host_rvalid !== 1'b0) begin
      errors++; $display("FAIL arb_accept: ready=%b rvalid=%b want 1/0", bus.host_ready, bus.host_rvalid);
    end
    @(negedge clk);
    checks++; if (bus.host_rvalid !== 1'b1 || bus.host_rdata !== VAL3 || bus.host_ready !== 1'b0) begin
      errors++; $display("FAIL arb_rresp: rvalid=%b rdata=%h ready=%b want 1/%h/0", bus.host_rvalid, bus.host_rdata, bus.host_ready, VAL3);
    end
    bus.host_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus.host_rvalid !== 1'b0 || bus.host_rdata !== VAL3 || bus.host_ready !== 1'b1) begin
      errors++; $display("FAIL arb_after: rvalid=%b rdata=%h ready=%b want 0/%h/1", bus.host_rvalid, bus.host_rdata, bus.host_ready, VAL3);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    idle_inputs();
    bus.host_valid = 1'b1; bus.host_addr = 8'd5;
    @(negedge clk);
    checks++; if (bus.host_rvalid !== 1'b1 || bus.host_rdata !== PRELOAD5) begin
      errors++; $display("FAIL b2b_first: rvalid=%b rdata=%h want 1/%h", bus.host_rvalid, bus.host_rdata, PRELOAD5);
    end
    bus.host_addr = 8'h10;
    @(negedge clk);
    checks++; if (bus.host_rvalid !== 1'b0 || bus.host_rdata !== PRELOAD5) begin
      errors++; $display("FAIL b2b_gap: rvalid=%b rdata=%h want 0/%h", bus.host_rvalid, bus.host_rdata, PRELOAD5);
    end
    @(negedge clk);
    checks++; if (bus.host_rvalid !== 1'b1 || bus.host_rdata !== BEEF) begin
      errors++; $display("FAIL b2b_second: rvalid=%b rdata=%h want 1/%h", bus.host_rvalid, bus.host_rdata, BEEF);
    end
    idle_inputs();
  endtask

  task automatic test_oob();
    host_write_word(8'hFF, VALFF);
    bus.mem_enable = 1'b1; bus.dmem_address = 32'h100;
    @(negedge clk);
    checks++; if (bus.dmem_dataOut !== 64'h0 || bus.oob_error !== 1'b1) begin
      errors++; $display("FAIL oob_load: dout=%h oob=%b want 0/1", bus.dmem_dataOut, bus.oob_error);
    end
    bus.store_enable = 1'b1; bus.dmem_address = 32'h1FF; bus.dmem_dataIn = 64'hBAD0BAD0BAD0BAD0;
    @(negedge clk);
    bus.store_enable = 1'b0; bus.dmem_address = 32'hFF;
    @(negedge clk);
    checks++; if (bus.dmem_dataOut !== VALFF) begin errors++; $display("FAIL oob_store_dropped: got %h want %h", bus.dmem_dataOut, VALFF); end
    checks++; if (bus.oob_error !== 1'b1) begin errors++; $display("FAIL oob_sticky: got %b want 1", bus.oob_error); end
    idle_inputs();
  endtask

  task automatic test_reset_rresp();
    @(negedge clk);
    bus.host_valid = 1'b1; bus.host_addr = 8'd3;
    @(negedge clk);
    checks++; if (bus.host_rvalid !== 1'b1) begin errors++; $display("FAIL rr_pre: rvalid=%b want 1", bus.host_rvalid); end
    #2 rst = 1'b1; bus.host_valid = 1'b0;
    #1;
    checks++; if (bus.host_rvalid !== 1'b0 || bus.host_ready !== 1'b0) begin
      errors++; $display("FAIL rr_async: rvalid=%b ready=%b want 0/0", bus.host_rvalid, bus.host_ready);
    end
    checks++; if (bus.dmem_dataOut !== 64'h0 || bus.host_rdata !== 64'h0 || bus.oob_error !== 1'b0) begin
      errors++; $display("FAIL rr_async_clear: dout=%h rdata=%h oob=%b want 0/0/0", bus.dmem_dataOut, bus.host_rdata, bus.oob_error);
    end
    #1 rst = 1'b0; #1;
    checks++; if (bus.host_ready !== 1'b1) begin errors++; $display("FAIL rr_release_ready: got %b want 1", bus.host_ready); end
    @(negedge clk);
    checks++; if (bus.host_rvalid !== 1'b0) begin errors++; $display("FAIL rr_lost: rvalid=%b want 0", bus.host_rvalid); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_host_preload();
    test_store_load();
    test_arbitration();
    test_back_to_back();
    test_oob();
    test_reset_rresp();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Single-port data memory serving as the responder end of the core's dmem interface (address, write data, store/memory enables in; read data out). Core accesses are serviced with one-cycle registered read latency, matching the core's ID-stage issue / EXE-MEM-stage consume timing. A secondary host port with valid/ready handshake preloads and dumps memory for test and boot, and is always lower priority than the core.

## Interface
- DATA_WIDTH, 64, word width of memory and data ports
- ADDR_WIDTH, 32, width of the core address port
- DEPTH_LOG2, 8, log2 of word count (256 words)
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  reset; asynchronous and active-high
- dmem_address  input  ADDR_WIDTH  core word address
- dmem_dataIn  input  DATA_WIDTH  core store data
- mem_enable  input  1  core access request this cycle
- store_enable  input  1  1 = store, 0 = load (qualified by mem_enable)
- dmem_dataOut  output  DATA_WIDTH  core load data, registered
- host_valid  input  1  host request valid
- host_ready  output  1  host request accepted when valid & ready at an edge
- host_write  input  1  1 = write, 0 = read
- host_addr  input  DEPTH_LOG2  host word address
- host_wdata  input  DATA_WIDTH  host write data
- host_rdata  output  DATA_WIDTH  host read data, registered
- host_rvalid  output  1  one-cycle pulse, host_rdata valid
- oob_error  output  1  sticky: core accessed an address ≥ 2^DEPTH_LOG2

## Operation
- Array: 2^DEPTH_LOG2 words of DATA_WIDTH; contents not cleared by reset (undefined until written).
- Core address in range iff dmem_address[ADDR_WIDTH-1:DEPTH_LOG2] == 0; index = low DEPTH_LOG2 bits.
- Core store (mem_enable=1, store_enable=1, in range): array[index] <= dmem_dataIn at the edge; dmem_dataOut unchanged.
- Core load (mem_enable=1, store_enable=0, in range): dmem_dataOut <= array[index] at the edge.
- Out of range: store dropped; load sets dmem_dataOut <= 0; oob_error <= 1 in both cases; stays 1 until rst.
- mem_enable=0: dmem_dataOut holds its last value.
- Host FSM, two states:
  - IDLE: host_ready = ~mem_enable. On host_valid & host_ready: write -> array[host_addr] <= host_wdata, stay IDLE; read -> host_rdata <= array[host_addr], go RRESP.
  - RRESP: host_ready = 0, host_rvalid = 1; next edge -> IDLE unconditionally.
- Core always wins: any cycle with mem_enable=1 forces host_ready=0; host must hold valid/write/addr/wdata stable until accepted.
- Core and host never touch the array on the same edge (single write/read port).

## Timing
- Reset values: dmem_dataOut=0, host_rdata=0, host_rvalid=0, oob_error=0, FSM=IDLE; host_ready=0 while rst=1.
- Core load latency: address/enable sampled at edge N, data valid from just after edge N until next load edge.
- Core store then load same address on consecutive edges: load returns new data (no bypass needed; write committed at first edge).
- Host write: committed at the accepting edge; visible to a core load at the next edge.
- Host read: accepted at edge N, host_rvalid=1 and host_rdata valid for cycle N..N+1; back-to-back host reads at most every 2 cycles.
- rst asserted mid host read: host_rvalid drops immediately, FSM to IDLE; pending request lost, host must reissue.
- host_valid asserted in RRESP: ignored until IDLE.
- host_rdata holds value after rvalid drops, until next host read.

## Test plan
- Reset: assert rst asynchronously mid-cycle -> dmem_dataOut, host_rdata, host_rvalid, oob_error all 0 immediately; host_ready 0 until rst releases.
- Host preload then core load: host writes 0x1122334455667788 to addr 5 -> core load addr 5 next cycle -> dmem_dataOut = 0x1122334455667788 one cycle after issue.
- Core store/load back-to-back: store 0xDEADBEEF to addr 0x10, load addr 0x10 next edge -> dmem_dataOut = 0xDEADBEEF; dmem_dataOut unchanged during the store cycle.
- Arbitration: host_valid held with read addr 3 while mem_enable=1 for 4 cycles -> host_ready=0 those cycles; accepted first cycle mem_enable=0; host_rvalid one cycle later for exactly 1 cycle with array[3].
- Out of range: core load addr 0x100 (DEPTH_LOG2=8) -> dmem_dataOut=0, oob_error=1 and stays 1 through later valid accesses; core store addr 0x1FF -> array[0xFF] unchanged.
- Reset during RRESP: rst pulses in the host_rvalid cycle -> host_rvalid=0, host_ready=1 after release with mem_enable=0.
